ldu_aq_gate: RTL

Load-issue acquire gate between the load dispatch path and the load pipeline. It enforces acquire ordering. It consumes the acquire advertisement registered by the store-AMO-fence unit acquire queue: mem active flag, io active flag and the oldest absolute ROB index of each. Loads younger than an active acquire are parked in a small collapsing hold queue until the acquire retires from the advertisement. Loads that are not blocked pass straight through to the load pipeline.

---
 rtl/ldu_aq_gate.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ldu_aq_gate.sv
// Load-issue acquire gate: parks loads younger than an active acquire in a collapsing hold queue.
// Optional macro LDU_AQ_GATE_IO_EN adds io-acquire blocking for io loads.
module ldu_aq_gate #(
  parameter int HOLD_ENTRIES    = 4,
  parameter int TAG_WIDTH       = 4,
  parameter int LOG_ROB_ENTRIES = 6,
  localparam int CNT_W          = $clog2(HOLD_ENTRIES + 1)
) (
  input  logic                       CLK,
  input  logic                       nRST,

  input  logic                       ldu_in_valid,
  input  logic [LOG_ROB_ENTRIES-1:0] ldu_in_ROB_index,
  input  logic                       ldu_in_is_io,
  input  logic [TAG_WIDTH-1:0]       ldu_in_tag,
  output logic                       ldu_in_ready,

  output logic                       ldu_out_valid,
  output logic [LOG_ROB_ENTRIES-1:0] ldu_out_ROB_index,
  output logic                       ldu_out_is_io,
  output logic [TAG_WIDTH-1:0]       ldu_out_tag,
  input  logic                       ldu_out_ready,

  input  logic                       stamofu_aq_mem_aq_active,
  input  logic [LOG_ROB_ENTRIES-1:0] stamofu_aq_mem_aq_oldest_abs_ROB_index,
  input  logic                       stamofu_aq_io_aq_active,
  input  logic [LOG_ROB_ENTRIES-1:0] stamofu_aq_io_aq_oldest_abs_ROB_index,

  input  logic [LOG_ROB_ENTRIES-1:0] rob_abs_head_index,
  input  logic                       rob_kill_valid,
  input  logic [LOG_ROB_ENTRIES-1:0] rob_kill_rel_kill_younger_index,

  output logic [CNT_W-1:0]           hold_count
);

  logic [HOLD_ENTRIES-1:0]    hold_valid, hold_valid_n;
  logic [LOG_ROB_ENTRIES-1:0] hold_rob   [HOLD_ENTRIES];
  logic [LOG_ROB_ENTRIES-1:0] hold_rob_n [HOLD_ENTRIES];
  logic                       hold_io    [HOLD_ENTRIES];
  logic                       hold_io_n  [HOLD_ENTRIES];
  logic [TAG_WIDTH-1:0]       hold_tag   [HOLD_ENTRIES];
  logic [TAG_WIDTH-1:0]       hold_tag_n [HOLD_ENTRIES];

  logic [HOLD_ENTRIES-1:0] hold_blk, hold_kill, hold_elig, sel_oh;
  logic                    sel_found;
  logic                    in_blk, in_kill, in_ok;
  logic                    fire, hold_rel, in_rel, in_store;

  // Ages are compared relative to the ROB head so wrap-around orders correctly.
  function automatic logic younger(input logic [LOG_ROB_ENTRIES-1:0] x,
                                   input logic [LOG_ROB_ENTRIES-1:0] aq_idx,
                                   input logic [LOG_ROB_ENTRIES-1:0] head);
    logic [LOG_ROB_ENTRIES-1:0] rel_x, rel_aq;
    rel_x  = x - head;
    rel_aq = aq_idx - head;
    return rel_x > rel_aq;
  endfunction

  function automatic logic is_killed(input logic [LOG_ROB_ENTRIES-1:0] x,
                                     input logic [LOG_ROB_ENTRIES-1:0] head,
                                     input logic                       kill_valid,
                                     input logic [LOG_ROB_ENTRIES-1:0] kill_idx);
    logic [LOG_ROB_ENTRIES-1:0] rel_x;
    rel_x = x - head;
    return kill_valid && (rel_x >= kill_idx);
  endfunction

`ifndef LDU_AQ_GATE_IO_EN
  logic unused_io_aq;
  assign unused_io_aq = ^{stamofu_aq_io_aq_active, stamofu_aq_io_aq_oldest_abs_ROB_index};
`endif

  always_comb begin
    in_blk = stamofu_aq_mem_aq_active &&
             younger(ldu_in_ROB_index, stamofu_aq_mem_aq_oldest_abs_ROB_index, rob_abs_head_index);
`ifdef LDU_AQ_GATE_IO_EN
    in_blk = in_blk | (ldu_in_is_io && stamofu_aq_io_aq_active &&
             younger(ldu_in_ROB_index, stamofu_aq_io_aq_oldest_abs_ROB_index, rob_abs_head_index));
`endif
    in_kill = is_killed(ldu_in_ROB_index, rob_abs_head_index, rob_kill_valid,
                        rob_kill_rel_kill_younger_index);
    in_ok   = ldu_in_valid && !in_blk && !in_kill;

    for (int i = 0; i < HOLD_ENTRIES; i++) begin
      hold_blk[i] = stamofu_aq_mem_aq_active &&
                    younger(hold_rob[i], stamofu_aq_mem_aq_oldest_abs_ROB_index, rob_abs_head_index);
`ifdef LDU_AQ_GATE_IO_EN
      hold_blk[i] = hold_blk[i] | (hold_io[i] && stamofu_aq_io_aq_active &&
                    younger(hold_rob[i], stamofu_aq_io_aq_oldest_abs_ROB_index, rob_abs_head_index));
`endif
      hold_kill[i] = is_killed(hold_rob[i], rob_abs_head_index, rob_kill_valid,
                               rob_kill_rel_kill_younger_index);
      hold_elig[i] = hold_valid[i] && !hold_blk[i] && !hold_kill[i];
    end

    sel_found = 1'b0;
    sel_oh    = '0;
    for (int i = 0; i < HOLD_ENTRIES; i++) begin
      if (hold_elig[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_oh[i] = 1'b1;
      end
    end

    ldu_out_valid     = nRST && (sel_found || in_ok);
    ldu_out_ROB_index = ldu_in_ROB_index;
    ldu_out_is_io     = ldu_in_is_io;
    ldu_out_tag       = ldu_in_tag;
    for (int i = 0; i < HOLD_ENTRIES; i++) begin
      if (sel_oh[i]) begin
        ldu_out_ROB_index = hold_rob[i];
        ldu_out_is_io     = hold_io[i];
        ldu_out_tag       = hold_tag[i];
      end
    end
  end

  always_comb begin
    hold_count = '0;
    for (int i = 0; i < HOLD_ENTRIES; i++) begin
      hold_count = hold_count + CNT_W'(hold_valid[i]);
    end
  end

  assign ldu_in_ready = hold_count < CNT_W'(HOLD_ENTRIES);

  assign fire     = ldu_out_valid && ldu_out_ready;
  assign hold_rel = fire && sel_found;
  assign in_rel   = fire && !sel_found;
  assign in_store = ldu_in_valid && ldu_in_ready && !in_kill && !in_rel;

  // Survivors collapse toward slot 0; an accepted input lands just above them.
  always_comb begin
    int wp;
    hold_valid_n = '0;
    hold_rob_n   = hold_rob;
    hold_io_n    = hold_io;
    hold_tag_n   = hold_tag;
    wp           = 0;
    for (int i = 0; i < HOLD_ENTRIES; i++) begin
      if (hold_valid[i] && !hold_kill[i] && !(hold_rel && sel_oh[i])) begin
        hold_valid_n[wp] = 1'b1;
        hold_rob_n[wp]   = hold_rob[i];
        hold_io_n[wp]    = hold_io[i];
        hold_tag_n[wp]   = hold_tag[i];
        wp               = wp + 1;
      end
    end
    if (in_store && (wp < HOLD_ENTRIES)) begin
      hold_valid_n[wp] = 1'b1;
      hold_rob_n[wp]   = ldu_in_ROB_index;
      hold_io_n[wp]    = ldu_in_is_io;
      hold_tag_n[wp]   = ldu_in_tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_valid <= '0;
    end else begin
      hold_valid <= hold_valid_n;
    end
    hold_rob <= hold_rob_n;
    hold_io  <= hold_io_n;
    hold_tag <= hold_tag_n;
  end

endmodule
